// File: rtl/draw_arbiter.sv
// draw_arbiter
// Round-robin arbiter plus filled-rectangle rasteriser that shares the single
// vga_adapter pixel-write port among N_REQ drawing requesters.
//
// Ports:
//   clk, rst            - system clock, synchronous active-high reset
//   req[N_REQ]          - per-requester command request (held until gnt)
//   cmd_x0/cmd_w        - packed per-requester left column / width (X_W each)
//   cmd_y0/cmd_h        - packed per-requester top row / height (Y_W each)
//   cmd_color           - packed per-requester fill colour (COLOR_W each)
//   gnt[N_REQ]          - one-cycle one-hot pulse when a command is accepted
//   done[N_REQ]         - one-cycle one-hot pulse when that rectangle is finished
//   busy                - high from the grant cycle through the done cycle
//   x, y, color, plot   - registered pixel write toward vga_adapter
module draw_arbiter #(
    parameter int N_REQ    = 4,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int COLOR_W  = 3,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*X_W-1:0]       cmd_x0,
    input  logic [N_REQ*Y_W-1:0]       cmd_y0,
    input  logic [N_REQ*X_W-1:0]       cmd_w,
    input  logic [N_REQ*Y_W-1:0]       cmd_h,
    input  logic [N_REQ*COLOR_W-1:0]   cmd_color,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [X_W-1:0]             x,
    output logic [Y_W-1:0]             y,
    output logic [COLOR_W-1:0]         color,
    output logic                       plot
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAW   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

    logic [1:0]       state;
    logic [IDX_W-1:0] last;     // index of the previous grant
    logic [IDX_W-1:0] cur;      // requester being drawn
    logic [IDX_W-1:0] win;      // round-robin winner this cycle
    logic [X_W-1:0]   lx0;      // latched left column, reloaded at each row end
    // Counters and end bounds carry one extra bit so x0+w / y0+h never wrap.
    logic [X_W:0]     cx, x_end, cx_inc;
    logic [Y_W:0]     cy, y_end, cy_inc;

    logic [X_W-1:0]     sel_x0, sel_w;
    logic [Y_W-1:0]     sel_y0, sel_h;
    logic [COLOR_W-1:0] sel_color;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % N_REQ);
    endfunction

    // Walk offsets from farthest to nearest so the requester closest after
    // `last` overwrites the others; offset N_REQ is `last` itself (lowest).
    always_comb begin
        win = last;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[wrap_idx(int'(last) + k)])
                win = wrap_idx(int'(last) + k);
        end
    end

    assign sel_x0    = cmd_x0[win*X_W +: X_W];
    assign sel_w     = cmd_w[win*X_W +: X_W];
    assign sel_y0    = cmd_y0[win*Y_W +: Y_W];
    assign sel_h     = cmd_h[win*Y_W +: Y_W];
    assign sel_color = cmd_color[win*COLOR_W +: COLOR_W];

    assign cx_inc = cx + 1'b1;
    assign cy_inc = cy + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= IDX_W'(N_REQ - 1);
            cur   <= '0;
            lx0   <= '0;
            cx    <= '0;
            cy    <= '0;
            x_end <= '0;
            y_end <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
        end else begin
            gnt  <= '0;
            done <= '0;
            plot <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt[win] <= 1'b1;
                        busy     <= 1'b1;
                        last     <= win;
                        cur      <= win;
                        lx0      <= sel_x0;
                        cx       <= {1'b0, sel_x0};
                        cy       <= {1'b0, sel_y0};
                        x_end    <= {1'b0, sel_x0} + {1'b0, sel_w};
                        y_end    <= {1'b0, sel_y0} + {1'b0, sel_h};
                        color    <= sel_color;
                        // An empty rectangle has no pixel cycles, so it goes
                        // straight to the done cycle to keep done at T+2.
                        state    <= (sel_w == '0 || sel_h == '0) ? ST_FINISH : ST_DRAW;
                    end else begin
                        // Cycle after done with nothing pending: drop busy.
                        busy <= 1'b0;
                    end
                end
                ST_DRAW: begin
                    x    <= cx[X_W-1:0];
                    y    <= cy[Y_W-1:0];
                    // Off-screen pixels still take their cycle, just unplotted.
                    plot <= (cx < SCR_W) && (cy < SCR_H);
                    if (cx_inc == x_end) begin
                        cx <= {1'b0, lx0};
                        if (cy_inc == y_end)
                            state <= ST_FINISH;
                        else
                            cy <= cy_inc;
                    end else begin
                        cx <= cx_inc;
                    end
                end
                ST_FINISH: begin
                    done[cur] <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
